// File: rtl/atd_pkg.sv
// Shared types and constants for the ATD sample-link receive path.
package atd_pkg;

  typedef enum logic {IDLE, RECV} atd_rx_state_t;

  localparam ATD_WORD_WIDTH = 8;

endpackage

// File: rtl/atd_word_receiver_timeout.sv
// Frame-timeout counter: counts idle cycles inside a word and flags the
// cycle on which the last allowed idle cycle passes without a shift pulse.
module atd_timeout_counter
  import atd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Idle-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A pulse on this cycle (clear) suppresses the timeout.
  assign expired = count_en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/atd_word_receiver.sv
// ATD serial-to-parallel receiver: assembles DATA_WIDTH-bit words from the
// edge detector's shift pulses and offers them on a valid/ready buffer with
// sticky overrun and one-cycle frame-timeout reporting.
module atd_word_receiver
  import atd_pkg::*;
#(
  parameter int DATA_WIDTH     = ATD_WORD_WIDTH,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ATD_data,
  input  logic                  ATD_shift_enable,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  atd_rx_state_t         state_q, state_d;
  logic                  data_q, data_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_error_q, frame_error_d;

  logic [DATA_WIDTH:0]   ext;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  complete;
  logic                  tmo_clear;
  logic                  tmo_count_en;
  logic                  tmo_expired;

  // Only RECV cycles without a pulse count as idle; IDLE holds the counter at 0.
  assign tmo_clear    = (state_q == IDLE) || ATD_shift_enable;
  assign tmo_count_en = (state_q == RECV) && !ATD_shift_enable;

  atd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .count_en(tmo_count_en),
    .expired (tmo_expired)
  );

  // Candidate shift-register value with the aligned data bit inserted.
  always_comb begin
    ext     = '0;
    shifted = shift_q;
    if (MSB_FIRST != 0) begin
      ext     = {shift_q, data_q};
      shifted = ext[DATA_WIDTH-1:0];
    end else begin
      ext     = {data_q, shift_q};
      shifted = ext[DATA_WIDTH:1];
    end
  end

  assign complete = ATD_shift_enable && (bit_cnt_q == LAST_BIT);

  // FSM next state, word assembly, output buffer and status flags.
  always_comb begin
    state_d       = state_q;
    data_d        = ATD_data;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    overrun_d     = overrun_q;
    frame_error_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    if (ATD_shift_enable) begin
      shift_d = shifted;
      if (complete) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        // A free or simultaneously drained buffer takes the word; otherwise
        // it is dropped and the sticky overrun set overrides any clear.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = shifted;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        state_d   = RECV;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else if ((state_q == RECV) && tmo_expired) begin
      state_d       = IDLE;
      bit_cnt_d     = '0;
      shift_d       = '0;
      frame_error_d = 1'b1;
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule
